mult_operand_sequencer: RTL and testbench
=========================================

# mult_operand_sequencer

Sequencing stage directly upstream and downstream of the combinational array multiplier built from full-adder cells. Accepts an operand pair over a valid/ready handshake and holds it stable on the array inputs for a fixed number of settle cycles. It then registers the array's product and presents it downstream over a second valid/ready handshake. It isolates the ripple-carry array's long combinational path from the chip I/O.

## Interface
Parameters:
- WIDTH, 4: operand width in bits; product is 2*WIDTH.
- SETTLE_CYCLES, 2: cycles the operands are held before the product is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- op_a  out  WIDTH  registered multiplicand driven to the array.
- op_b  out  WIDTH  registered multiplier driven to the array.
- prod_in  in  2*WIDTH  combinational product returned by the array.
- out_valid  out  1  product register valid.
- out_ready  in  1  downstream accepts the product.
- product  out  2*WIDTH  registered product.
- err  out  1  sticky self-check mismatch flag (see Configuration).

## Operation
- FSM with three states: IDLE, SETTLE, HOLD. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a->op_a and b->op_b, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: in_ready=0, out_valid=0, op_a/op_b held constant. The counter decrements each cycle. In the cycle where the counter is 0, capture prod_in->product, set out_valid, and go to HOLD.
- HOLD: out_valid=1, product held constant until accepted.
  - in_ready = out_ready (combinational).
  - out_ready=1 with in_valid=0: clear out_valid, go to IDLE.
  - out_ready=1 with in_valid=1: accept the new pair (latch op_a/op_b, reload counter), go to SETTLE. out_valid is 0 next cycle.
  - out_ready=0: stay; in_valid is ignored.
- in_valid in SETTLE is ignored; upstream must hold the pair until in_ready.
- Arithmetic: the block does no arithmetic on the datapath. product is prod_in exactly, 2*WIDTH bits, unsigned.
- op_a and op_b change only on an accepted input handshake.

## Timing
- Reset values:
  - in_ready=0 while rst is asserted, 1 from the first cycle after deassertion.
  - out_valid=0, product=0, op_a=0, op_b=0, err=0, counter=0.
- Latency: input accepted at edge N -> out_valid=1 after edge N+SETTLE_CYCLES.
- Throughput with out_ready held at 1: one product every SETTLE_CYCLES+1 cycles.
- SETTLE_CYCLES=1 gives a single SETTLE cycle.
- Reset asserted mid-SETTLE or mid-HOLD:
  - The in-flight operation is abandoned immediately and asynchronously.
  - out_valid drops with no handshake.
  - product, op_a, op_b and err return to 0.
- out_valid never deasserts without out_ready, except on reset.

## Configuration
- MULT_SEQ_SELFCHECK_EN defined:
  - At the product capture edge, prod_in is compared with an internal behavioral op_a*op_b (2*WIDTH bits).
  - A mismatch sets err=1; err stays set until rst.
- MULT_SEQ_SELFCHECK_EN undefined: no comparator is synthesized, and err is tied to 0. The port remains present.

## Test plan
- Basic, WIDTH=4, SETTLE_CYCLES=2, out_ready=1: a=4'hF, b=4'hD, accepted at edge 0 -> op_a=F, op_b=D after edge 0; out_valid=1 and product=8'hC3 after edge 2; out_valid=0 after edge 3.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> product and out_valid are stable, in_ready=0, a new in_valid is ignored. Raising out_ready with in_valid=1 (a=3, b=5) gives product=8'h0F two cycles after acceptance.
- Back-to-back with out_ready=1 and in_valid=1 continuously, pairs (1,1), (2,3), (F,F) -> products 01, 06, E1, one every 3 cycles, in order.
- Reset during SETTLE, one cycle after accepting (7,7) -> out_valid=0, op_a=0, op_b=0, product=0 immediately; after release in_ready=1 and the next pair completes normally.
- Zero and edge operands (0,F) and (F,0) -> product=00; (8,2) -> 10.
- With MULT_SEQ_SELFCHECK_EN, force prod_in bit 0 inverted for one operation -> err=1 after the capture edge, sticky across later correct products, cleared only by rst. Without the macro, err stays 0.

Source files
------------

// File: rtl/mult_operand_sequencer.sv
// Operand/product register stage around a combinational array multiplier.
// Optional product self-check enabled by defining MULT_SEQ_SELFCHECK_EN.
module mult_operand_sequencer #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH-1:0]   prod_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 err
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t     state, state_next;
    logic [3:0] cnt;
    logic       ready_int;
    logic       load;
    logic       capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_int  = 1'b0;
        load       = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                ready_int = out_ready;
                if (out_ready) begin
                    load       = in_valid;
                    state_next = in_valid ? SETTLE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset gates ready so upstream never sees a handshake while the block is held.
    assign in_ready = ready_int & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                op_a <= a;
                op_b <= b;
                cnt  <= CNT_LOAD;
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (capture) begin
                product   <= prod_in;
                out_valid <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MULT_SEQ_SELFCHECK_EN
    logic [2*WIDTH-1:0] expected;

    assign expected = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (capture && prod_in != expected) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer (WIDTH=4, SETTLE_CYCLES=2) with a
// behavioural array model driving prod_in.
module tb_mult_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [7:0] prod_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       err;
    logic       flip;

    int total = 0;
    int bad   = 0;

    mult_operand_sequencer #(
        .WIDTH(4),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .op_a(op_a),
        .op_b(op_b),
        .prod_in(prod_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product(product),
        .err(err)
    );

    // Array model; flip corrupts bit 0 to exercise the self-check.
    assign prod_in = (8'(op_a) * 8'(op_b)) ^ {7'b0, flip};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with out_ready=1 held throughout.
    task automatic run_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                          input logic [7:0] exp);
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_opa"}, 16'(op_a), 16'(va));
        check({tag, "_opb"}, 16'(op_b), 16'(vb));
        tick();
        check({tag, "_nv1"}, 16'(out_valid), 16'd0);
        tick();
        check({tag, "_ov"}, 16'(out_valid), 16'd1);
        check({tag, "_prod"}, 16'(product), 16'(exp));
        tick();
        check({tag, "_drop"}, 16'(out_valid), 16'd0);
        check({tag, "_rdy"}, 16'(in_ready), 16'd1);
    endtask

    logic [3:0] pa [3];
    logic [3:0] pb [3];
    logic [7:0] pe [3];

    initial begin
        int idx;
        int n;
        int last;
        logic hs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; flip = 1'b0;
        #12;
        check("rst_rdy", 16'(in_ready), 16'd0);
        check("rst_ov", 16'(out_valid), 16'd0);
        check("rst_prod", 16'(product), 16'd0);
        check("rst_opa", 16'(op_a), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rel_rdy", 16'(in_ready), 16'd1);
        tick();

        // Basic F*D
        a = 4'hF; b = 4'hD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("b_opa", 16'(op_a), 16'hF);
        check("b_opb", 16'(op_b), 16'hD);
        check("b_busy", 16'(in_ready), 16'd0);
        tick();
        check("b_nv", 16'(out_valid), 16'd0);
        tick();
        check("b_ov", 16'(out_valid), 16'd1);
        check("b_prod", 16'(product), 16'hC3);
        tick();
        check("b_drop", 16'(out_valid), 16'd0);

        // Backpressure
        a = 4'h2; b = 4'h7; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bp_ov", 16'(out_valid), 16'd1);
        check("bp_prod", 16'(product), 16'h0E);
        a = 4'h3; b = 4'h5; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_ov", 16'(out_valid), 16'd1);
            check("bp_hold_prod", 16'(product), 16'h0E);
            check("bp_hold_rdy", 16'(in_ready), 16'd0);
            check("bp_hold_opa", 16'(op_a), 16'h2);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_comb", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        check("bp_acc_ov", 16'(out_valid), 16'd0);
        check("bp_acc_opa", 16'(op_a), 16'h3);
        tick();
        tick();
        check("bp_ov2", 16'(out_valid), 16'd1);
        check("bp_prod2", 16'(product), 16'h0F);
        tick();

        // Back-to-back
        pa[0] = 4'h1; pb[0] = 4'h1; pe[0] = 8'h01;
        pa[1] = 4'h2; pb[1] = 4'h3; pe[1] = 8'h06;
        pa[2] = 4'hF; pb[2] = 4'hF; pe[2] = 8'hE1;
        idx = 0; n = 0; last = 0;
        a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
            hs = in_valid & in_ready;
            tick();
            if (hs) begin
                idx++;
                if (idx < 3) begin
                    a = pa[idx]; b = pb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("b2b_prod", 16'(product), 16'(pe[n]));
                if (n > 0) check("b2b_gap", 16'(cyc - last), 16'd3);
                last = cyc;
                n++;
            end
        end
        check("b2b_count", 16'(n), 16'd3);
        in_valid = 1'b0;
        tick();
        tick();

        // Reset during SETTLE
        a = 4'h7; b = 4'h7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mr_ov", 16'(out_valid), 16'd0);
        check("mr_opa", 16'(op_a), 16'd0);
        check("mr_opb", 16'(op_b), 16'd0);
        check("mr_prod", 16'(product), 16'd0);
        check("mr_rdy", 16'(in_ready), 16'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mr_rel_rdy", 16'(in_ready), 16'd1);
        run_op("mr_next", 4'h8, 4'h2, 8'h10);

        // Zero / edge operands
        run_op("z0F", 4'h0, 4'hF, 8'h00);
        run_op("zF0", 4'hF, 4'h0, 8'h00);
        run_op("e82", 4'h8, 4'h2, 8'h10);
        check("err_clean", 16'(err), 16'd0);

        // Corrupted product
        flip = 1'b1;
        run_op("bad", 4'h5, 4'h3, 8'h0E);
        flip = 1'b0;
`ifdef MULT_SEQ_SELFCHECK_EN
        check("err_set", 16'(err), 16'd1);
        run_op("good", 4'h4, 4'h4, 8'h10);
        check("err_sticky", 16'(err), 16'd1);
        rst = 1'b1;
        #1;
        check("err_rst", 16'(err), 16'd0);
        tick();
        rst = 1'b0;
`else
        check("err_off", 16'(err), 16'd0);
        run_op("good", 4'h4, 4'h4, 8'h10);
        check("err_off2", 16'(err), 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
